// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 funct3 codes, AHB-Lite
// encodings, FSM states and small decode helpers.
package lsu_pkg;

    localparam int unsigned XLEN_DEF     = 32;
    localparam int unsigned RF_IDX_W_DEF = 5;

    // RV32 load/store size/sign codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // AHB-Lite encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } lsu_state_e;

    // Undefined encodings (011, 110, 111) behave as a word access.
    function automatic logic [2:0] norm_funct3(input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: norm_funct3 = f3;
            default:                        norm_funct3 = F3_W;
        endcase
    endfunction

    // Size is carried in funct3[1:0] once normalised.
    function automatic logic [2:0] hsize_of(input logic [2:0] f3n);
        case (f3n[1:0])
            2'b00:   hsize_of = HSIZE_BYTE;
            2'b01:   hsize_of = HSIZE_HALF;
            default: hsize_of = HSIZE_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3n, input logic [1:0] addr_lo);
        case (f3n[1:0])
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = addr_lo[0];
            default: is_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: picks the addressed byte/half lane out of the 32-bit
// read bus and sign- or zero-extends it.
//   hrdata_i    : raw AHB read data
//   addr_lo_i   : registered address bits [1:0] of the transfer
//   funct3_i    : normalised RV32 funct3
//   load_data_o : aligned, extended result
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] hrdata_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] load_data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v      = hrdata_i[{addr_lo_i, 3'b000} +: 8];
        half_v      = addr_lo_i[1] ? hrdata_i[31:16] : hrdata_i[15:0];
        load_data_o = hrdata_i;
        case (funct3_i)
            F3_B:    load_data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_BU:   load_data_o = {{(XLEN-8){1'b0}}, byte_v};
            F3_H:    load_data_o = {{(XLEN-16){half_v[15]}}, half_v};
            F3_HU:   load_data_o = {{(XLEN-16){1'b0}}, half_v};
            default: load_data_o = hrdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_ahb_master.sv
// Load/store unit: takes one request at a time from EX, runs a single AHB-Lite
// transfer (address phase, data phase) and returns load writeback data.
//   req_*            : EX request handshake and payload
//   lsu_busy         : transfer in flight
//   misalign_err     : one-cycle pulse, request rejected as misaligned
//   bus_err          : one-cycle pulse, slave answered ERROR
//   wb_en/wb_rd/...  : load writeback to the register file
//   H*               : AHB-Lite master port
module lsu_ahb_master
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEF,
    parameter int unsigned RF_IDX_W  = RF_IDX_W_DEF,
    parameter logic [3:0]  HPROT_VAL = HPROT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_is_load,
    input  logic [2:0]          req_funct3,
    input  logic [XLEN-1:0]     req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    input  logic [RF_IDX_W-1:0] req_rd,
    output logic                lsu_busy,
    output logic                misalign_err,
    output logic                bus_err,
    output logic                wb_en,
    output logic [RF_IDX_W-1:0] wb_rd,
    output logic [XLEN-1:0]     wb_data,
    output logic [XLEN-1:0]     HADDR,
    output logic [1:0]          HTRANS,
    output logic                HWRITE,
    output logic [2:0]          HSIZE,
    output logic [2:0]          HBURST,
    output logic [3:0]          HPROT,
    output logic [XLEN-1:0]     HWDATA,
    input  logic [XLEN-1:0]     HRDATA,
    input  logic                HREADY,
    input  logic                HRESP
);

    lsu_state_e          state_q, state_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [1:0]          htrans_q, htrans_d;
    logic                write_q, write_d;
    logic [2:0]          size_q, size_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [RF_IDX_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]     hwdata_q, hwdata_d;
    logic                wb_en_q, wb_en_d;
    logic [RF_IDX_W-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]     wb_data_q, wb_data_d;
    logic                mis_q, mis_d;
    logic                berr_q, berr_d;

    logic [2:0]          req_f3n;
    logic [XLEN-1:0]     store_lanes;
    logic [XLEN-1:0]     load_word;

    lsu_load_align #(.XLEN(XLEN)) u_align (
        .hrdata_i    (HRDATA),
        .addr_lo_i   (addr_q[1:0]),
        .funct3_i    (funct3_q),
        .load_data_o (load_word)
    );

    // Request decode: normalised funct3 and byte-lane replicated store data
    always_comb begin
        req_f3n = norm_funct3(req_funct3);
        case (req_f3n[1:0])
            2'b00:   store_lanes = {(XLEN/8){req_wdata[7:0]}};
            2'b01:   store_lanes = {(XLEN/16){req_wdata[15:0]}};
            default: store_lanes = req_wdata;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            htrans_q  <= HTRANS_IDLE;
            write_q   <= 1'b0;
            size_q    <= HSIZE_BYTE;
            funct3_q  <= F3_B;
            rd_q      <= '0;
            hwdata_q  <= '0;
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            mis_q     <= 1'b0;
            berr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            htrans_q  <= htrans_d;
            write_q   <= write_d;
            size_q    <= size_d;
            funct3_q  <= funct3_d;
            rd_q      <= rd_d;
            hwdata_q  <= hwdata_d;
            wb_en_q   <= wb_en_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            mis_q     <= mis_d;
            berr_q    <= berr_d;
        end
    end

    // Next-state logic; pulses default low, everything else holds
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        htrans_d  = htrans_q;
        write_d   = write_q;
        size_d    = size_q;
        funct3_d  = funct3_q;
        rd_d      = rd_q;
        hwdata_d  = hwdata_q;
        wb_en_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        mis_d     = 1'b0;
        berr_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (is_misaligned(req_f3n, req_addr[1:0])) begin
                        mis_d = 1'b1;
                    end else begin
                        state_d  = ST_ADDR;
                        htrans_d = HTRANS_NONSEQ;
                        addr_d   = req_addr;
                        write_d  = !req_is_load;
                        size_d   = hsize_of(req_f3n);
                        funct3_d = req_f3n;
                        rd_d     = req_rd;
                        // Load keeps the previous HWDATA to avoid needless toggling
                        if (!req_is_load) begin
                            hwdata_d = store_lanes;
                        end
                    end
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    state_d  = ST_DATA;
                    htrans_d = HTRANS_IDLE;
                end
            end
            ST_DATA: begin
                if (HREADY) begin
                    state_d = ST_IDLE;
                    if (HRESP) begin
                        berr_d = 1'b1;
                    end else if (!write_q && (rd_q != '0)) begin
                        wb_en_d   = 1'b1;
                        wb_rd_d   = rd_q;
                        wb_data_d = load_word;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                htrans_d = HTRANS_IDLE;
            end
        endcase
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign lsu_busy     = (state_q != ST_IDLE);
    assign misalign_err = mis_q;
    assign bus_err      = berr_q;
    assign wb_en        = wb_en_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign HADDR        = addr_q;
    assign HTRANS       = htrans_q;
    assign HWRITE       = write_q;
    assign HSIZE        = size_q;
    assign HBURST       = HBURST_SINGLE;
    assign HPROT        = HPROT_VAL;
    assign HWDATA       = hwdata_q;

endmodule
